// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for subtrator_serial: FSM state encoding, slice width
// and the WIDTH legality check used at elaboration.
package subtrator_serial_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The serial datapath consumes SLICE_W bits per cycle, so WIDTH must be a
  // non-zero multiple of it.
  function automatic bit width_ok(input int w);
    return (w >= SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Start/done handshake and operand/result bus of subtrator_serial.
// The ovf signal exists only when SUBTRATOR_SERIAL_OVF_EN is defined.
interface subtrator_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin,
                  input  ready, busy, done, diff, bout, ovf);
  modport slave  (input  start, a, b, bin,
                  output ready, busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin,
                  input  ready, busy, done, diff, bout);
  modport slave  (input  start, a, b, bin,
                  output ready, busy, done, diff, bout);
`endif

endinterface

// File: rtl/subtrator_serial_slice.sv
// 2-bit ripple-borrow subtractor slice (Subtrator2Bits) built from two
// 1-bit full subtractors. Purely combinational.
module Subtrator1Bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module Subtrator2Bits (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bin,
  output logic [1:0] diff,
  output logic       bout
);
  logic borrow_mid;

  Subtrator1Bit u_bit0 (
    .a    (a[0]),
    .b    (b[0]),
    .bin  (bin),
    .diff (diff[0]),
    .bout (borrow_mid)
  );

  Subtrator1Bit u_bit1 (
    .a    (a[1]),
    .b    (b[1]),
    .bin  (borrow_mid),
    .diff (diff[1]),
    .bout (bout)
  );
endmodule

// File: rtl/subtrator_serial.sv
// Multi-cycle WIDTH-bit subtractor computing a - b - bin two bits per clock
// through one shared Subtrator2Bits slice, with a start/ready/done handshake.
// Optional feature: define SUBTRATOR_SERIAL_OVF_EN to add the signed
// overflow flag (ovf) and the sampled operand MSB storage it needs.
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  subtrator_serial_if.slave  bus
);
  localparam int STEPS = WIDTH / SLICE_W;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("subtrator_serial: WIDTH must be even and at least 2");
  end

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr, res_nxt, diff_q;
  logic               borrow_q, bout_q;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;
  logic               last;
  logic               ready, busy, done;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic               a_msb, b_msb, ovf_q;
`endif

  Subtrator2Bits u_slice (
    .a    (a_sr[SLICE_W-1:0]),
    .b    (b_sr[SLICE_W-1:0]),
    .bin  (borrow_q),
    .diff (slice_d),
    .bout (slice_bout)
  );

  // New slice bits enter at the top; after STEPS shifts the LSB pair has
  // reached bit 0. Written as shifts so WIDTH == SLICE_W needs no special case.
  assign res_nxt = (res_sr >> SLICE_W) | (WIDTH'(slice_d) << (WIDTH - SLICE_W));
  assign last    = (state == S_RUN) && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is looked at only in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last)      state_nxt = S_DONE;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_RUN:   busy  = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Operand capture, serial shift/borrow chain and result registers.
  // Results are captured on the edge entering DONE so they are valid
  // together with the done pulse and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            borrow_q <= bus.bin;
            cnt      <= '0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          a_sr     <= a_sr >> SLICE_W;
          b_sr     <= b_sr >> SLICE_W;
          res_sr   <= res_nxt;
          borrow_q <= slice_bout;
          if (last) begin
            diff_q <= res_nxt;
            bout_q <= slice_bout;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            ovf_q  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
